// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and lock-FSM types for the VGA
// generator and the receive-side sync decoder.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL     = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL     = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int H_ACT_END   = H_ACT_START + H_VISIBLE - 1;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int V_ACT_END   = V_ACT_START + V_VISIBLE - 1;

  localparam logic SYNC_POL    = 1'b0;
  localparam int   LOCK_FRAMES = 2;

  localparam int               CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  // True when a sync pin sits at its asserted level.
  function automatic logic sync_level(input logic pin, input logic pol);
    return pin == pol;
  endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Video link between a VGA source (master) and the sync decoder (slave),
// including the decoder's recovered-coordinate and status outputs.
interface vga_sync_decoder_if;
  import vga_timing_pkg::*;

  logic             h_sync;
  logic             v_sync;
  logic [3:0]       red;
  logic [3:0]       green;
  logic [3:0]       blue;

  logic [CNT_W-1:0] x_loc;
  logic [CNT_W-1:0] y_loc;
  logic             video_on;
  logic [3:0]       pix_r;
  logic [3:0]       pix_g;
  logic [3:0]       pix_b;
  logic             locked;
  logic             frame_start;
  logic             sync_err;
  logic [CNT_W-1:0] line_len;
  logic [CNT_W-1:0] frame_lines;

  modport master (
    output h_sync, v_sync, red, green, blue,
    input  x_loc, y_loc, video_on, pix_r, pix_g, pix_b,
           locked, frame_start, sync_err, line_len, frame_lines
  );

  modport slave (
    input  h_sync, v_sync, red, green, blue,
    output x_loc, y_loc, video_on, pix_r, pix_g, pix_b,
           locked, frame_start, sync_err, line_len, frame_lines
  );

endinterface

// File: rtl/vga_edge_det.sv
// Polarity-normalised sync level with assert/deassert edge pulses and a
// saturating count of how many cycles the pulse stayed asserted.
module vga_edge_det
  import vga_timing_pkg::*;
#(
  parameter logic ASSERT_LVL = SYNC_POL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_in,
  output logic             level,
  output logic             assert_edge,
  output logic             deassert_edge,
  output logic [CNT_W-1:0] width
);

  logic             level_q;
  logic [CNT_W-1:0] cnt;

  assign level         = sync_level(sync_in, ASSERT_LVL);
  assign assert_edge   = level & ~level_q;
  assign deassert_edge = ~level & level_q;
  // Valid on the deassert edge: number of cycles the pulse was asserted.
  assign width         = cnt;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      level_q <= level;
      if (assert_edge)
        cnt <= CNT_W'(1);
      else if (level && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: rebuilds pixel coordinates from h/v sync,
// checks timing against nominal, and reports lock, errors and measurements.
module vga_sync_decoder #(
  parameter int   H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
  parameter int   H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int   H_BACK      = vga_timing_pkg::H_BACK,
  parameter int   V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
  parameter int   V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int   V_BACK      = vga_timing_pkg::V_BACK,
  parameter logic SYNC_POL    = vga_timing_pkg::SYNC_POL,
  parameter int   LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input logic               clk,
  input logic               rst_n,
  vga_sync_decoder_if.slave vga
);
  import vga_timing_pkg::*;

  localparam int GC_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [CNT_W-1:0] H_TOT  = CNT_W'(H_SYNC + H_BACK + H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] V_TOT  = CNT_W'(V_SYNC + V_BACK + V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] H_WID  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_LO   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_HI   = CNT_W'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] V_LO   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_HI   = CNT_W'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [GC_W-1:0]  GC_TGT = GC_W'(LOCK_FRAMES);

  logic             hs_lvl, hs_assert, hs_deassert;
  logic [CNT_W-1:0] hs_width;
  logic             vs_lvl, vs_hist;
  logic             v_edge;

  logic [CNT_W-1:0] hc, vc, hc_inc, vc_inc, hc_nxt, vc_nxt;
  logic [CNT_W-1:0] line_meas, frame_meas;

  logic             line_bad, width_bad, frame_bad, sync_lost, violation;
  logic             in_window, vid_nxt;

  lock_state_e      state, state_nxt;
  logic [GC_W-1:0]  good_cnt, good_nxt;

  vga_edge_det #(.ASSERT_LVL(SYNC_POL)) u_hs_det (
    .clk           (clk),
    .rst_n         (rst_n),
    .sync_in       (vga.h_sync),
    .level         (hs_lvl),
    .assert_edge   (hs_assert),
    .deassert_edge (hs_deassert),
    .width         (hs_width)
  );

  assign vs_lvl = sync_level(vga.v_sync, SYNC_POL);
  assign v_edge = hs_assert & vs_lvl & ~vs_hist;

  // hc_nxt/vc_nxt are the coordinates of the sample on the bus this cycle;
  // everything registered below is derived from them for 1-cycle latency.
  assign hc_inc = (hc == CNT_MAX) ? hc : hc + 1'b1;
  assign vc_inc = (vc == CNT_MAX) ? vc : vc + 1'b1;
  assign hc_nxt = hs_assert ? '0 : hc_inc;
  assign vc_nxt = v_edge ? '0 : (hs_assert ? vc_inc : vc);

  assign line_meas  = hc + 1'b1;
  assign frame_meas = vc + 1'b1;

  assign line_bad  = hs_assert && (line_meas != H_TOT);
  assign width_bad = hs_deassert && (hs_width != H_WID);
  assign frame_bad = v_edge && (frame_meas != V_TOT);
  assign sync_lost = (hc_nxt == CNT_MAX) && (hc != CNT_MAX);
  assign violation = (state != SEARCH) &&
                     (line_bad || width_bad || frame_bad || sync_lost);

  assign in_window = (hc_nxt >= H_LO) && (hc_nxt <= H_HI) &&
                     (vc_nxt >= V_LO) && (vc_nxt <= V_HI);
  assign vid_nxt   = (state_nxt == LOCKED) && in_window;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    unique case (state)
      SEARCH: begin
        if (v_edge) begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (violation) begin
          state_nxt = SEARCH;
          good_nxt  = '0;
        end else if (v_edge) begin
          good_nxt = good_cnt + 1'b1;
          if (good_nxt == GC_TGT)
            state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (violation) begin
          state_nxt = SEARCH;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      hc       <= '0;
      vc       <= '0;
      vs_hist  <= 1'b0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      hc       <= hc_nxt;
      vc       <= vc_nxt;
      if (hs_assert)
        vs_hist <= vs_lvl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.x_loc       <= '0;
      vga.y_loc       <= '0;
      vga.video_on    <= 1'b0;
      vga.pix_r       <= '0;
      vga.pix_g       <= '0;
      vga.pix_b       <= '0;
      vga.locked      <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.sync_err    <= 1'b0;
      vga.line_len    <= '0;
      vga.frame_lines <= '0;
    end else begin
      vga.video_on    <= vid_nxt;
      vga.x_loc       <= vid_nxt ? hc_nxt - H_LO : '0;
      vga.y_loc       <= vid_nxt ? vc_nxt - V_LO : '0;
      vga.pix_r       <= vid_nxt ? vga.red   : '0;
      vga.pix_g       <= vid_nxt ? vga.green : '0;
      vga.pix_b       <= vid_nxt ? vga.blue  : '0;
      vga.locked      <= (state_nxt == LOCKED);
      vga.frame_start <= (state == LOCKED) && v_edge && !violation;
      vga.sync_err    <= violation;
      if (hs_assert)
        vga.line_len <= line_meas;
      if (v_edge)
        vga.frame_lines <= frame_meas;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken raster (26x12 clocks)
// so lock, relock and saturation scenarios fit in a few thousand cycles.
module tb_vga_sync_decoder;
  import vga_timing_pkg::*;

  localparam int HS = 4, HB = 3, HV = 16, HF = 3, HT = HS + HB + HV + HF;  // 26
  localparam int VS = 2, VB = 2, VV = 6,  VF = 2, VT = VS + VB + VV + VF;  // 12
  localparam int HLO = HS + HB;  // 7
  localparam int VLO = VS + VB;  // 4

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_decoder_if bus ();

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int g_vc  = 0;
  bit chk_pix = 1'b0;
  int err_cnt = 0;
  int fs_cnt  = 0;
  int err_base, fs_base;

  always @(negedge clk) begin
    if (bus.sync_err)    err_cnt++;
    if (bus.frame_start) fs_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pix_checks(input int p);
    if (g_vc == VLO) begin
      if (p == HLO - 1) check("von_before_win", bus.video_on, 0);
      if (p == HLO) begin
        check("x_first", bus.x_loc, 0);
        check("y_first", bus.y_loc, 0);
        check("von_first", bus.video_on, 1);
        check("r_first", bus.pix_r, 0);
        check("g_first", bus.pix_g, 4);
        check("b_first", bus.pix_b, 10);
      end
      if (p == HLO + HV - 1) begin
        check("x_last", bus.x_loc, HV - 1);
        check("r_last", bus.pix_r, 15);
        check("von_last", bus.video_on, 1);
      end
      if (p == HLO + HV) begin
        check("von_after_win", bus.video_on, 0);
        check("x_after_win", bus.x_loc, 0);
        check("r_after_win", bus.pix_r, 0);
        check("b_after_win", bus.pix_b, 0);
      end
    end
    if (g_vc == VLO + VV - 1 && p == 10) begin
      check("y_last_row", bus.y_loc, VV - 1);
      check("x_last_row", bus.x_loc, 3);
      check("g_last_row", bus.pix_g, 9);
    end
    if (g_vc == VLO + VV && p == 10) begin
      check("von_below", bus.video_on, 0);
      check("y_below", bus.y_loc, 0);
    end
  endtask

  // One generator clock at column p of line g_vc; hsync (active-low) spans
  // columns [0, hs_w), vsync spans lines [0, VS).
  task automatic gen_px(input int p, input int hs_w);
    int x;
    x = p - HLO;
    bus.h_sync = (p < hs_w) ? 1'b0 : 1'b1;
    bus.v_sync = (g_vc < VS) ? 1'b0 : 1'b1;
    bus.red    = 4'(x);
    bus.green  = 4'(g_vc);
    bus.blue   = 4'hA;
    cyc();
    if (chk_pix) pix_checks(p);
  endtask

  task automatic gen_line_from(input int p0, input int len, input int hs_w);
    for (int p = p0; p < len; p++) gen_px(p, hs_w);
    g_vc = (g_vc + 1) % VT;
  endtask

  task automatic finish_frame();
    while (g_vc != 0) gen_line_from(0, HT, HS);
  endtask

  task automatic gen_frames(input int n);
    repeat (n * VT) gen_line_from(0, HT, HS);
  endtask

  // From mid-frame after a violation: ACQUIRE at the next frame start, then
  // two good frames, lock on the third V edge.
  task automatic relock(input string tag);
    finish_frame();
    gen_frames(2);
    check({tag, "_not_yet_locked"}, bus.locked, 0);
    gen_px(0, HS);
    check({tag, "_relocked"}, bus.locked, 1);
    gen_line_from(1, HT, HS);
  endtask

  initial begin
    bus.h_sync = 1'b1;
    bus.v_sync = 1'b1;
    bus.red    = '0;
    bus.green  = '0;
    bus.blue   = '0;

    repeat (3) cyc();
    check("rst_locked", bus.locked, 0);
    check("rst_video_on", bus.video_on, 0);
    check("rst_line_len", bus.line_len, 0);
    check("rst_frame_lines", bus.frame_lines, 0);
    check("rst_sync_err", bus.sync_err, 0);
    check("rst_state", int'(dut.state), int'(SEARCH));
    rst_n = 1'b1;

    // Nominal frames: ACQUIRE on V edge 1, lock on V edge 3.
    err_base = err_cnt;
    gen_px(0, HS);
    check("acq_on_edge1", int'(dut.state), int'(ACQUIRE));
    gen_line_from(1, HT, HS);
    finish_frame();
    gen_frames(1);
    check("locked_before_edge3", bus.locked, 0);
    check("line_len_nominal", bus.line_len, HT);
    check("frame_lines_nominal", bus.frame_lines, VT);
    gen_px(0, HS);
    check("locked_after_edge3", bus.locked, 1);
    check("state_locked", int'(dut.state), int'(LOCKED));
    fs_base = fs_cnt;
    gen_line_from(1, HT, HS);
    finish_frame();
    gen_px(0, HS);
    check("frame_start_edge4", bus.frame_start, 1);
    chk_pix = 1'b1;
    gen_line_from(1, HT, HS);
    finish_frame();
    chk_pix = 1'b0;
    check("frame_start_count", fs_cnt - fs_base, 1);
    check("no_err_nominal", err_cnt - err_base, 0);

    // Over-long line: error lands on the following H edge.
    while (g_vc != 5) gen_line_from(0, HT, HS);
    gen_line_from(0, HT + 1, HS);
    gen_px(0, HS);
    check("long_sync_err", bus.sync_err, 1);
    check("long_line_len", bus.line_len, HT + 1);
    check("long_locked", bus.locked, 0);
    check("long_state", int'(dut.state), int'(SEARCH));
    gen_line_from(1, HT, HS);
    relock("long");

    // Short hsync: error on the deassert edge.
    while (g_vc != 3) gen_line_from(0, HT, HS);
    err_base = err_cnt;
    for (int p = 0; p < HS - 1; p++) gen_px(p, HS - 1);
    check("short_no_err_early", bus.sync_err, 0);
    gen_px(HS - 1, HS - 1);
    check("short_sync_err", bus.sync_err, 1);
    check("short_locked", bus.locked, 0);
    gen_line_from(HS, HT, HS - 1);
    check("short_err_once", err_cnt - err_base, 1);
    relock("short");

    // Asynchronous reset mid visible line while locked.
    while (g_vc != 5) gen_line_from(0, HT, HS);
    for (int p = 0; p < 10; p++) gen_px(p, HS);
    check("pre_rst_video_on", bus.video_on, 1);
    check("pre_rst_x", bus.x_loc, 2);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_video_on", bus.video_on, 0);
    check("mid_rst_locked", bus.locked, 0);
    check("mid_rst_x", bus.x_loc, 0);
    check("mid_rst_pix_r", bus.pix_r, 0);
    check("mid_rst_line_len", bus.line_len, 0);
    check("mid_rst_frame_lines", bus.frame_lines, 0);
    gen_line_from(10, HT, HS);
    rst_n = 1'b1;
    relock("post_rst");

    // hsync stuck deasserted: hc saturates, one error only.
    err_base = err_cnt;
    for (int q = HT; q < 1200; q++) begin
      gen_px(q, 0);
      if (q == 1022) check("sat_no_err_early", bus.sync_err, 0);
      if (q == 1023) begin
        check("sat_sync_err", bus.sync_err, 1);
        check("sat_locked", bus.locked, 0);
      end
    end
    check("sat_err_once", err_cnt - err_base, 1);
    check("sat_state", int'(dut.state), int'(SEARCH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of our VGA timing generator. Takes h_sync/v_sync and 4-bit RGB on the pixel clock and rebuilds pixel coordinates and a video-on flag. Checks the incoming 640x480@60 timing against nominal and reports lock, errors and measured line/frame lengths. Used as the on-chip checker/capture front end for the VGA pipeline, and as a loopback monitor in benches.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of h_sync/v_sync (0 = active-low)
LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
clk  in  1  pixel clock (25 MHz, same domain as the VGA generator's divided clock)
rst_n  in  1  asynchronous active-low reset
h_sync  in  1  horizontal sync, synchronous to clk
v_sync  in  1  vertical sync, synchronous to clk
red  in  4  pixel red
green  in  4  pixel green
blue  in  4  pixel blue
x_loc  out  10  recovered column, 0..639 when video_on, else 0
y_loc  out  10  recovered row, 0..479 when video_on, else 0
video_on  out  1  recovered active-video flag
pix_r  out  4  registered red, 0 when video_on=0
pix_g  out  4  registered green, 0 when video_on=0
pix_b  out  4  registered blue, 0 when video_on=0
locked  out  1  timing lock
frame_start  out  1  one-cycle pulse at each frame start while locked
sync_err  out  1  one-cycle pulse on any timing violation
line_len  out  10  clocks in the last complete line
frame_lines  out  10  lines in the last complete frame

Behaviour:
- Reset (async, rst_n=0): all outputs 0. hc=0, vc=0, state SEARCH, good-frame count 0, sync history registers deasserted.
- Inputs are synchronous to clk; no synchronizers. The h_sync/v_sync level is compared with SYNC_POL and registered once for edge detection.
- H assert edge: first cycle h_sync is at the asserted level. On that cycle:
  - line_len <= hc+1
  - hc <= 0
  - vc <= vc+1
  - v_sync is sampled into vs_hist.
- Otherwise hc increments and saturates at 1023.
- V assert edge: an H assert edge where v_sync is asserted and vs_hist was deasserted. On that edge: vc <= 0 and frame_lines <= vc+1.
- hsync width: counted to the H deassert edge. Width != H_SYNC is a violation.
- Timing windows:
  - H_TOTAL = 800, V_TOTAL = 525.
  - Visible window: hc in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1] = [144,783] and vc in [35,514].
  - x = hc-144, y = vc-35.
- Output latency: outputs are registered with 1-cycle latency. Outputs at cycle t+1 describe the inputs sampled at cycle t.
- video_on gating: video_on = locked AND in window. When 0, x_loc, y_loc and pix_* are forced to 0.
- FSM, SEARCH:
  - locked=0.
  - On a V assert edge -> ACQUIRE, good count 0.
- FSM, ACQUIRE:
  - Each V edge with frame_lines==V_TOTAL increments the good count.
  - When the count reaches LOCK_FRAMES -> LOCKED; locked=1 from the next cycle.
- FSM, LOCKED:
  - locked=1.
  - frame_start pulses the cycle after each V assert edge.
- Violations, checked only in ACQUIRE/LOCKED:
  - line_len != H_TOTAL at an H edge
  - hsync width != H_SYNC
  - frame_lines != V_TOTAL at a V edge
  - hc reaching 1023 (sync lost)
- On any violation: sync_err pulses for one cycle, state -> SEARCH, locked=0 next cycle, good count 0.
- Simultaneous events:
  - A violation and a lock-qualifying V edge in the same cycle: the violation wins.
  - A V edge that is itself the violating edge does not re-enter ACQUIRE on that cycle; re-acquire waits for the next V edge.
- Measurements: line_len and frame_lines update in every state, including SEARCH.
- Saturation: vc saturates at 1023.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480 timing constants and derived H_TOTAL/V_TOTAL and window bounds
  - lock FSM state enum {SEARCH, ACQUIRE, LOCKED}
- The VGA generator shares the same package.
- One sub-module, vga_edge_det: polarity-normalised level, assert/deassert edge pulses and pulse-width counter. Instantiated for h_sync; v_sync uses only the level.

Test Plan:
1. Reset asserted mid-line after lock -> all outputs 0 immediately. After release, locked stays 0 until 2 good frames have passed.
2. Three frames of nominal 640x480 from the generator -> state ACQUIRE at V edge 1, locked=1 the cycle after V edge 3, frame_start pulses each frame thereafter. line_len=800, frame_lines=525.
3. Generator drives red=x[3:0] while locked -> cycle after hc=144 on vc=35: x_loc=0, y_loc=0, video_on=1, pix_r=0. After hc=783: x_loc=639, pix_r=15. After hc=784: video_on=0 and x_loc=0.
4. One 801-clock line while locked -> sync_err pulse at the next H edge, line_len=801, locked=0, state SEARCH. Relock after the following 3 V edges.
5. hsync pulse of 95 clocks while locked -> sync_err at the deassert edge, locked drops.
6. h_sync held deasserted after lock -> hc saturates at 1023, sync_err pulses once, locked=0. No further sync_err while still in SEARCH.
